systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
Sequencer for the N x N output-stationary systolic_array (16-bit operand lanes, 32-bit accumulators). Holds operand matrices A and B loaded through a word-write port. On start it clears the array, feeds the diagonally skewed a/b lane vectors over 2N-1 cycles and waits a drain period. It then captures the N x N result, pulses done and hands the result to the host side.

Parameters:
N, 4, array dimension (rows = cols = lanes)
DATA_W, 16, operand width per lane
ACC_W, 32, accumulator/result element width
DRAIN_CYCLES, 4, cycles between last feed step and result capture (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
ld_valid  in  1  operand write strobe
ld_ready  out  1  high in IDLE only; write accepted when ld_valid & ld_ready
ld_sel  in  1  0 = matrix A, 1 = matrix B
ld_row  in  $clog2(N)  element row index
ld_col  in  $clog2(N)  element column index
ld_data  in  DATA_W  element value
start  in  1  run request, sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when c_out is updated
c_valid  out  1  c_out holds the result of the last completed run
c_out  out  N*N*ACC_W  captured result, element (i,j) at [(i*N+j+1)*ACC_W-1 -: ACC_W]
arr_clr_n  out  1  active-low clear to array accumulators (ANDed with rst_n at top level)
a_out  out  N*DATA_W  row lanes to array, lane i at [(i+1)*DATA_W-1 -: DATA_W]
b_out  out  N*DATA_W  column lanes to array, lane j at same slicing
res_in  in  N*N*ACC_W  array result bus, same layout as c_out

Behaviour:
- Reset values: state IDLE; ld_ready=1, busy=0, done=0, c_valid=0, c_out=0, arr_clr_n=1, a_out=b_out=0, all A/B storage =0, counters =0.
- All outputs are registered.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> CAPTURE -> IDLE.
- IDLE: accepted ld writes set A or B [ld_row][ld_col] <= ld_data at the edge. start=1 at edge k moves to CLEAR and clears c_valid.
- Load and start in the same cycle: the write lands at edge k and the run uses the new value.
- CLEAR (one cycle, after edge k): arr_clr_n=0. The state moves to FEED at edge k+1.
- FEED: step counter s=0..2N-2. Step s is presented after edge k+1+s.
  - a lane i = A[i][s-i] if 0<=s-i<N, else 0.
  - b lane j = B[s-j][j] if 0<=s-j<N, else 0.
  - After the last step the state moves to DRAIN, and a_out and b_out return to 0.
- DRAIN: runs exactly DRAIN_CYCLES cycles with zero lanes.
- CAPTURE: c_out <= res_in, c_valid <= 1 and done=1 in the same cycle, then IDLE.
- Latency: start sampled at edge k gives done and c_out valid after edge k+2N+DRAIN_CYCLES+1. For N=4 and DRAIN_CYCLES=4 this is edge k+13.
- Boundaries:
  - start while busy: ignored, no queuing.
  - ld_valid while busy: not accepted, storage unchanged.
  - start held high continuously: a new run begins each time IDLE is re-entered.
  - c_out holds its value until the next CAPTURE.
- Reset mid-run: immediate return to reset values, including storage and c_valid. Lanes go to 0 asynchronously.
- Arithmetic is done in the array; the controller never modifies data widths. Counter widths are $clog2(2N) and $clog2(DRAIN_CYCLES+1).

Decomposition:
- Package sa_pkg holds: N, DATA_W, ACC_W defaults; localparam FEED_STEPS=2*N-1; typedef enum ctrl_state_t {IDLE, CLEAR, FEED, DRAIN, CAPTURE}; typedef logic [DATA_W-1:0] operand_t.
- One sub-module, sa_operand_buf: A/B register storage with write port plus combinational skew selection of a/b lanes for step s. The FSM, counters and output registers stay in systolic_array_ctrl.

Test Plan:
- A=B=[[1..4],[5..8],[9..12],[13..16]], start -> done 13 cycles after start. c_out rows: [90 100 110 120], [202 228 254 280], [314 356 398 440], [426 484 542 600].
- Skew check, same data -> step 0 a_out={0,0,0,1}, b_out lane0=1; step 3 a_out lanes 0..3 = 4,7,10,13; step 6 a lane3=16, b lane3=16, other lanes 0.
- Second run with A=identity, B unchanged, without reset -> arr_clr_n low one cycle after start; c_out = B exactly (no accumulation from the previous run).
- start and ld_valid pulsed during FEED -> ld_ready=0, no extra done, storage unchanged, result unchanged.
- rst_n dropped during DRAIN -> all outputs at reset values; a following load and run produces the correct product.
- ld write and start in the same cycle (A[0][0]=2, others as scenario 1) -> c_out row0 = [91 102 113 124].

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Imported by the controller and its operand buffer.
package sa_pkg;
  localparam int N = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W = 32;
  localparam int DRAIN_CYCLES = 4;
  localparam int FEED_STEPS = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE
  } ctrl_state_t;

  typedef logic [DATA_W-1:0] operand_t;
endpackage

// File: rtl/sa_operand_buf.sv
// A/B operand storage with a word-write port.
// Also selects the diagonally skewed lane values for a given feed step.
module sa_operand_buf
  import sa_pkg::*;
#(
  parameter int N = sa_pkg::N,
  parameter int DATA_W = sa_pkg::DATA_W,
  localparam int RW = $clog2(N),
  localparam int SW = $clog2(2 * N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                sel,
  input  logic [RW-1:0]       row,
  input  logic [RW-1:0]       col,
  input  logic [DATA_W-1:0]   data,
  input  logic [SW-1:0]       step,
  output logic [N*DATA_W-1:0] a_lanes,
  output logic [N*DATA_W-1:0] b_lanes
);
  logic [N-1:0][N-1:0][DATA_W-1:0] a_q, a_d;
  logic [N-1:0][N-1:0][DATA_W-1:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (we) begin
      if (sel) b_d[row][col] = data;
      else a_d[row][col] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Lane i carries the element on anti-diagonal `step`, zero outside the matrix.
  always_comb begin
    a_lanes = '0;
    b_lanes = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(step) >= i && int'(step) - i < N) begin
        a_lanes[i*DATA_W +: DATA_W] = a_q[i][RW'(int'(step) - i)];
        b_lanes[i*DATA_W +: DATA_W] = b_q[RW'(int'(step) - i)][i];
      end
    end
  end
endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for an N x N output-stationary systolic array:
// clear, skewed feed, drain, capture of the result matrix.
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int N = sa_pkg::N,
  parameter int DATA_W = sa_pkg::DATA_W,
  parameter int ACC_W = sa_pkg::ACC_W,
  parameter int DRAIN_CYCLES = sa_pkg::DRAIN_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic                   ld_sel,
  input  logic [$clog2(N)-1:0]   ld_row,
  input  logic [$clog2(N)-1:0]   ld_col,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   c_valid,
  output logic [N*N*ACC_W-1:0]   c_out,
  output logic                   arr_clr_n,
  output logic [N*DATA_W-1:0]    a_out,
  output logic [N*DATA_W-1:0]    b_out,
  input  logic [N*N*ACC_W-1:0]   res_in
);
  localparam int SW = $clog2(2 * N);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int STEPS = 2 * N - 1;

  ctrl_state_t state_q, state_d;
  logic [SW-1:0] step_q, step_d, sel_step;
  logic [DW-1:0] drain_q, drain_d;
  logic ld_ready_q, ld_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic c_valid_q, c_valid_d;
  logic clr_n_q, clr_n_d;
  logic [N*N*ACC_W-1:0] c_q, c_d;
  logic [N*DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [N*DATA_W-1:0] a_lanes, b_lanes;

  // Lanes are precomputed one step ahead so they can be registered.
  assign sel_step = (state_q == FEED) ? step_q + 1'b1 : '0;

  sa_operand_buf #(
    .N(N),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .we(ld_valid & ld_ready_q),
    .sel(ld_sel),
    .row(ld_row),
    .col(ld_col),
    .data(ld_data),
    .step(sel_step),
    .a_lanes(a_lanes),
    .b_lanes(b_lanes)
  );

  always_comb begin
    state_d = state_q;
    step_d = step_q;
    drain_d = drain_q;
    c_valid_d = c_valid_q;
    c_d = c_q;
    done_d = 1'b0;
    clr_n_d = 1'b1;
    a_d = '0;
    b_d = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          c_valid_d = 1'b0;
          clr_n_d = 1'b0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        step_d = '0;
        a_d = a_lanes;
        b_d = b_lanes;
      end
      FEED: begin
        if (step_q == SW'(STEPS - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          step_d = step_q + 1'b1;
          a_d = a_lanes;
          b_d = b_lanes;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = CAPTURE;
        else drain_d = drain_q + 1'b1;
      end
      CAPTURE: begin
        state_d = IDLE;
        c_d = res_in;
        c_valid_d = 1'b1;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    ld_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      drain_q <= '0;
      ld_ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      c_valid_q <= 1'b0;
      clr_n_q <= 1'b1;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      drain_q <= drain_d;
      ld_ready_q <= ld_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      c_valid_q <= c_valid_d;
      clr_n_q <= clr_n_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign ld_ready = ld_ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign c_valid = c_valid_q;
  assign c_out = c_q;
  assign arr_clr_n = clr_n_q & rst_n;
  assign a_out = a_q;
  assign b_out = b_q;
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a behavioural
// output-stationary 4x4 array closing the loop on res_in.
module tb_systolic_array_ctrl;
  logic clk;
  logic rst_n;
  logic ld_valid;
  logic ld_ready;
  logic ld_sel;
  logic [1:0] ld_row;
  logic [1:0] ld_col;
  logic [15:0] ld_data;
  logic start;
  logic busy;
  logic done;
  logic c_valid;
  logic [511:0] c_out;
  logic arr_clr_n;
  logic [63:0] a_out;
  logic [63:0] b_out;
  logic [511:0] res_in;

  int total = 0;
  int bad = 0;

  systolic_array_ctrl #(
    .N(4),
    .DATA_W(16),
    .ACC_W(32),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_sel(ld_sel),
    .ld_row(ld_row),
    .ld_col(ld_col),
    .ld_data(ld_data),
    .start(start),
    .busy(busy),
    .done(done),
    .c_valid(c_valid),
    .c_out(c_out),
    .arr_clr_n(arr_clr_n),
    .a_out(a_out),
    .b_out(b_out),
    .res_in(res_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: a moves right, b moves down, each PE accumulates a*b.
  logic [3:0][3:0][31:0] acc;
  logic [3:0][3:0][15:0] ar;
  logic [3:0][3:0][15:0] br;
  assign res_in = acc;

  always @(posedge clk) begin
    if (!arr_clr_n) begin
      acc <= '0;
      ar <= '0;
      br <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          logic [15:0] ai;
          logic [15:0] bi;
          ai = (j == 0) ? a_out[i*16 +: 16] : ar[i][j-1];
          bi = (i == 0) ? b_out[j*16 +: 16] : br[i-1][j];
          acc[i][j] <= acc[i][j] + 32'(ai) * 32'(bi);
          ar[i][j] <= ai;
          br[i][j] <= bi;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pk(input int m[16]);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = m[k][31:0];
    return r;
  endfunction

  task automatic ld(input logic s, input int r, input int c, input int d);
    ld_valid = 1'b1;
    ld_sel = s;
    ld_row = r[1:0];
    ld_col = c[1:0];
    ld_data = d[15:0];
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_seq(input logic s);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ld(s, r, c, r * 4 + c + 1);
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [511:0] exp1, expb, exp6;
  int em[16];
  int nd;

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0;
    ld_sel = 1'b0;
    ld_row = '0;
    ld_col = '0;
    ld_data = '0;
    start = 1'b0;
    em = '{90, 100, 110, 120, 202, 228, 254, 280,
           314, 356, 398, 440, 426, 484, 542, 600};
    exp1 = pk(em);
    em = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    expb = pk(em);
    em = '{91, 102, 113, 124, 202, 228, 254, 280,
           314, 356, 398, 440, 426, 484, 542, 600};
    exp6 = pk(em);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_clr_n", arr_clr_n, 1);
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);

    // Run 1: A = B = 1..16, with skew checks
    load_seq(1'b0);
    load_seq(1'b1);
    go();
    chk("r1_clr_low", arr_clr_n, 0);
    chk("r1_busy", busy, 1);
    chk("r1_ld_ready", ld_ready, 0);
    @(negedge clk);
    chk("r1_clr_high", arr_clr_n, 1);
    chk("r1_s0_a", a_out, 64'h0000_0000_0000_0001);
    chk("r1_s0_b", b_out, 64'h0000_0000_0000_0001);
    repeat (3) @(negedge clk);
    chk("r1_s3_a", a_out, 64'h000D_000A_0007_0004);
    repeat (3) @(negedge clk);
    chk("r1_s6_a", a_out, 64'h0010_0000_0000_0000);
    chk("r1_s6_b", b_out, 64'h0010_0000_0000_0000);
    @(negedge clk);
    chk("r1_drain_a", a_out, 0);
    chk("r1_drain_b", b_out, 0);
    repeat (4) @(negedge clk);
    chk("r1_done_early", done, 0);
    chk("r1_cv_early", c_valid, 0);
    @(negedge clk);
    chk("r1_done", done, 1);
    chk("r1_c_valid", c_valid, 1);
    chk("r1_c_out", c_out, exp1);
    @(negedge clk);
    chk("r1_done_pulse", done, 0);
    chk("r1_hold", c_out, exp1);

    // Run 2: A = identity, no reset in between
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ld(1'b0, r, c, (r == c) ? 1 : 0);
    go();
    chk("r2_clr_low", arr_clr_n, 0);
    repeat (13) @(negedge clk);
    chk("r2_done", done, 1);
    chk("r2_c_out", c_out, expb);

    // Run 3: start and a write pulsed during FEED are ignored
    go();
    repeat (2) @(negedge clk);
    start = 1'b1;
    ld_valid = 1'b1;
    ld_sel = 1'b0;
    ld_row = 2'd0;
    ld_col = 2'd0;
    ld_data = 16'd99;
    @(negedge clk);
    chk("r3_ld_ready", ld_ready, 0);
    start = 1'b0;
    ld_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("r3_done", done, 1);
    chk("r3_c_out", c_out, expb);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("r3_no_extra_done", nd, 0);
    chk("r3_idle", busy, 0);

    // Run 4: reset during DRAIN
    go();
    repeat (9) @(negedge clk);
    chk("r4_busy_drain", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r4_rst_busy", busy, 0);
    chk("r4_rst_ld_ready", ld_ready, 1);
    chk("r4_rst_c_valid", c_valid, 0);
    chk("r4_rst_c_out", c_out, 0);
    chk("r4_rst_a", a_out, 0);
    chk("r4_rst_b", b_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r4_clr_n", arr_clr_n, 1);
    load_seq(1'b0);
    load_seq(1'b1);
    go();
    repeat (13) @(negedge clk);
    chk("r4_done", done, 1);
    chk("r4_c_out", c_out, exp1);

    // Run 5: write A[0][0]=2 in the same cycle as start
    ld_valid = 1'b1;
    ld_sel = 1'b0;
    ld_row = 2'd0;
    ld_col = 2'd0;
    ld_data = 16'd2;
    start = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("r5_done", done, 1);
    chk("r5_c_out", c_out, exp6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
